// File: rtl/accel_averager.sv
// Boxcar averager for the accelerometer Y/Z words: samples every SAMPLE_DIV cycles,
// averages 2^LOG2_N samples per axis and classifies board tilt from the averages.
module accel_averager #(
    parameter int unsigned SAMPLE_DIV  = 100000,
    parameter int unsigned LOG2_N      = 4,
    parameter int          TILT_THRESH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Y_value,
    input  logic [15:0] Z_value,
    output logic [15:0] y_avg,
    output logic [15:0] z_avg,
    output logic        avg_valid,
    output logic [1:0]  tilt
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned ACC_W  = DATA_W + LOG2_N;

    localparam logic [CNT_W-1:0]         TICK_AT  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [LOG2_N-1:0]        LAST_SMP = {LOG2_N{1'b1}};
    localparam logic signed [DATA_W-1:0] THR_POS  = DATA_W'(TILT_THRESH);
    localparam logic signed [DATA_W-1:0] THR_NEG  = DATA_W'(-TILT_THRESH);

    typedef enum logic {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] y_s1, y_s2, z_s1, z_s2;
    logic [CNT_W-1:0]  timer;
    logic [LOG2_N-1:0] sample_cnt;
    logic [ACC_W-1:0]  acc_y, acc_z;

    logic                     tick_c;
    logic signed [DATA_W-1:0] y_new_c, z_new_c;
    logic [1:0]               tilt_new_c;

    assign tick_c = (timer == TICK_AT);

    // Arithmetic shift by LOG2_N keeping the low 16 bits is exactly the top 16 accumulator bits.
    assign y_new_c = acc_y[ACC_W-1 -: DATA_W];
    assign z_new_c = acc_z[ACC_W-1 -: DATA_W];

    // Tilt priority: inverted board dominates, then strict signed Y thresholds.
    always_comb begin
        tilt_new_c = 2'b00;
        if (z_new_c < 0) begin
            tilt_new_c = 2'b11;
        end else if (y_new_c > THR_POS) begin
            tilt_new_c = 2'b01;
        end else if (y_new_c < THR_NEG) begin
            tilt_new_c = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (tick_c && (sample_cnt == LAST_SMP)) state_d = DUMP;
            DUMP:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Synchronisers, free-running sample timer, accumulation and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_s1       <= '0;
            y_s2       <= '0;
            z_s1       <= '0;
            z_s2       <= '0;
            timer      <= '0;
            sample_cnt <= '0;
            acc_y      <= '0;
            acc_z      <= '0;
            y_avg      <= '0;
            z_avg      <= '0;
            tilt       <= '0;
            avg_valid  <= 1'b0;
        end else begin
            y_s1      <= Y_value;
            y_s2      <= y_s1;
            z_s1      <= Z_value;
            z_s2      <= z_s1;
            timer     <= tick_c ? '0 : timer + CNT_W'(1);
            avg_valid <= 1'b0;
            if (state_q == DUMP) begin
                y_avg      <= y_new_c;
                z_avg      <= z_new_c;
                tilt       <= tilt_new_c;
                avg_valid  <= 1'b1;
                acc_y      <= '0;
                acc_z      <= '0;
                sample_cnt <= '0;
            end else if (tick_c) begin
                acc_y      <= acc_y + {{LOG2_N{y_s2[DATA_W-1]}}, y_s2};
                acc_z      <= acc_z + {{LOG2_N{z_s2[DATA_W-1]}}, z_s2};
                sample_cnt <= sample_cnt + LOG2_N'(1);
            end
        end
    end

endmodule

// File: tb/tb_accel_averager.sv
// Directed bench for accel_averager with SAMPLE_DIV=4, LOG2_N=4: back-to-back 64-cycle
// averaging windows, threshold and rounding corners, reset mid-window and in the dump cycle.
module tb_accel_averager;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] Y_value, Z_value;
    logic [15:0] y_avg, z_avg;
    logic        avg_valid;
    logic [1:0]  tilt;

    int tests = 0;
    int fails = 0;

    logic [15:0] yq[16];
    logic [15:0] zq[16];
    logic        pend;
    logic [15:0] py, pz;
    logic [1:0]  pt;
    string       ptag;

    accel_averager #(
        .SAMPLE_DIV (4),
        .LOG2_N     (4),
        .TILT_THRESH(256)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Y_value  (Y_value),
        .Z_value  (Z_value),
        .y_avg    (y_avg),
        .z_avg    (z_avg),
        .avg_valid(avg_valid),
        .tilt     (tilt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] y, input logic [15:0] z);
        for (int i = 0; i < 16; i++) begin
            yq[i] = y;
            zq[i] = z;
        end
    endtask

    task automatic check_pending();
        chk({ptag, ".valid"}, 32'(avg_valid), 32'd1);
        chk({ptag, ".y_avg"}, 32'(y_avg), 32'(py));
        chk({ptag, ".z_avg"}, 32'(z_avg), 32'(pz));
        chk({ptag, ".tilt"},  32'(tilt),  32'(pt));
    endtask

    // Entered mid-cycle at a window base; one new sample value per 4-cycle tick period.
    // The previous window's result is due in the first cycle of this one.
    task automatic window(input string tag, input logic [15:0] ey, input logic [15:0] ez,
                          input logic [1:0] et);
        int spurious = 0;
        for (int c = 0; c < 64; c++) begin
            if (c % 4 == 0) begin
                Y_value = yq[c / 4];
                Z_value = zq[c / 4];
            end
            @(negedge clk);
            if (c == 0 && pend) check_pending();
            else if (avg_valid !== 1'b0) spurious++;
        end
        chk({tag, ".no_stray_valid"}, 32'(spurious), 32'd0);
        pend = 1'b1;
        py   = ey;
        pz   = ez;
        pt   = et;
        ptag = tag;
    endtask

    task automatic flush();
        @(negedge clk);
        if (pend) check_pending();
        pend = 1'b0;
    endtask

    initial begin
        pend    = 1'b0;
        reset   = 1'b1;
        Y_value = 16'h1234;
        Z_value = 16'h0000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst.y_avg", 32'(y_avg), 32'd0);
        chk("rst.z_avg", 32'(z_avg), 32'd0);
        chk("rst.tilt",  32'(tilt),  32'd0);
        chk("rst.valid", 32'(avg_valid), 32'd0);
        reset = 1'b0;

        fill(16'h0100, 16'h0100);
        window("const1", 16'h0100, 16'h0100, 2'b00);
        window("const2", 16'h0100, 16'h0100, 2'b00);
        fill(16'hFF00, 16'h0100);
        window("yneg256", 16'hFF00, 16'h0100, 2'b00);
        fill(16'hFEFF, 16'h0100);
        window("yneg257", 16'hFEFF, 16'h0100, 2'b10);
        fill(16'h0500, 16'hFFFF);
        window("zneg", 16'h0500, 16'hFFFF, 2'b11);
        fill(16'h0000, 16'h0000);
        yq[15] = 16'hFFFF;
        window("round", 16'hFFFF, 16'h0000, 2'b00);
        fill(16'h7FFF, 16'h7FFF);
        window("maxpos", 16'h7FFF, 16'h7FFF, 2'b01);
        fill(16'h8000, 16'h0000);
        window("maxneg", 16'h8000, 16'h0000, 2'b10);
        fill(16'h0010, 16'h8000);
        for (int i = 1; i < 16; i += 2) yq[i] = 16'h0030;
        window("mixed", 16'h0020, 16'h8000, 2'b11);
        fill(16'h0101, 16'h0000);
        window("ypos257", 16'h0101, 16'h0000, 2'b01);
        fill(16'h0200, 16'h0100);
        window("dumprst", 16'h0200, 16'h0100, 2'b01);

        // Reset lands on the dump cycle: result must never appear.
        pend  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("dumprst.valid", 32'(avg_valid), 32'd0);
        chk("dumprst.y_avg", 32'(y_avg), 32'd0);
        chk("dumprst.z_avg", 32'(z_avg), 32'd0);
        chk("dumprst.tilt",  32'(tilt),  32'd0);

        // Seven ticks of 0x0400, then reset; the partial sum must be discarded.
        reset   = 1'b0;
        Y_value = 16'h0400;
        Z_value = 16'h0000;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fill(16'h0000, 16'h0000);
        window("midrst", 16'h0000, 16'h0000, 2'b00);
        flush();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
